// File: rtl/mult_job_sequencer_if.sv
// Job, result, status and AXI4-Lite master bundle for mult_job_sequencer.
// master: sequencer side; slave: job producer plus AXI slave side.
interface mult_job_sequencer_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 16
);
    logic          job_valid;
    logic          job_ready;
    logic [31:0]   job_a;
    logic [31:0]   job_b;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_data;
    logic          res_err;
    logic          busy;
    logic [CW-1:0] jobs_done;
    logic [CW-1:0] err_cnt;

    logic [AW-1:0] M_AXI_AWADDR;
    logic [2:0]    M_AXI_AWPROT;
    logic          M_AXI_AWVALID;
    logic          M_AXI_AWREADY;
    logic [31:0]   M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_WVALID;
    logic          M_AXI_WREADY;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BVALID;
    logic          M_AXI_BREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY;
    logic [31:0]   M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;
    logic          M_AXI_RVALID;
    logic          M_AXI_RREADY;

    modport master (
        input  job_valid, job_a, job_b, res_ready,
        output job_ready, res_valid, res_data, res_err,
        output busy, jobs_done, err_cnt,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output job_valid, job_a, job_b, res_ready,
        input  job_ready, res_valid, res_data, res_err,
        input  busy, jobs_done, err_cnt,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/mult_job_sequencer.sv
// AXI4-Lite master running one multiply job at a time: writes A, B, reads P.
// Ports: ACLK, ARESETN (async active-low), bus (mult_job_sequencer_if.master).
module mult_job_sequencer #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_OFS_A = 'h0,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_OFS_B = 'h4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_OFS_P = 'h8,
    parameter int unsigned C_CNT_WIDTH = 16
) (
    input logic ACLK,
    input logic ARESETN,
    mult_job_sequencer_if.master bus
);
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE, WR_A, WR_A_RSP, WR_B, WR_B_RSP, RD_P, RD_P_RSP, DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [DW-1:0]          a_q, a_d;
    logic [DW-1:0]          b_q, b_d;
    logic [DW-1:0]          res_q, res_d;
    logic                   err_q, err_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [C_CNT_WIDTH-1:0] jobs_q, jobs_d;
    logic [C_CNT_WIDTH-1:0] errc_q, errc_d;

    logic                          job_ready;
    logic                          busy;
    logic                          aw_valid;
    logic                          w_valid;
    logic                          b_ready;
    logic                          ar_valid;
    logic                          r_ready;
    logic                          res_valid;
    logic                          res_err;
    logic [C_M_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [DW-1:0]                 w_data;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            jobs_q    <= '0;
            errc_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            jobs_q    <= jobs_d;
            errc_q    <= errc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        jobs_d    = jobs_q;
        errc_d    = errc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.job_valid) begin
                    a_d     = bus.job_a;
                    b_d     = bus.job_b;
                    err_d   = 1'b0;
                    state_d = WR_A;
                end
            end
            WR_A, WR_B: begin
                // AW and W complete independently, in any order
                aw_done_d = aw_done_q | bus.M_AXI_AWREADY;
                w_done_d  = w_done_q | bus.M_AXI_WREADY;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (state_q == WR_A) ? WR_A_RSP : WR_B_RSP;
                end
            end
            WR_A_RSP, WR_B_RSP: begin
                if (bus.M_AXI_BVALID) begin
                    if (bus.M_AXI_BRESP != 2'b00) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = (state_q == WR_A_RSP) ? WR_B : RD_P;
                    end
                end
            end
            RD_P: begin
                if (bus.M_AXI_ARREADY) state_d = RD_P_RSP;
            end
            RD_P_RSP: begin
                if (bus.M_AXI_RVALID) begin
                    res_d = bus.M_AXI_RDATA;
                    if (bus.M_AXI_RRESP != 2'b00) err_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    jobs_d = jobs_q + 1'b1;
                    if (err_q) errc_d = errc_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        job_ready = 1'b0;
        busy      = 1'b1;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        res_valid = 1'b0;
        res_err   = 1'b0;
        aw_addr   = C_BASE_ADDR + C_OFS_A;
        w_data    = a_q;
        unique case (state_q)
            IDLE: begin
                job_ready = ARESETN;
                busy      = 1'b0;
            end
            WR_A: begin
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
            end
            WR_B: begin
                aw_valid = !aw_done_q;
                w_valid  = !w_done_q;
                aw_addr  = C_BASE_ADDR + C_OFS_B;
                w_data   = b_q;
            end
            WR_A_RSP, WR_B_RSP: b_ready = 1'b1;
            RD_P:               ar_valid = 1'b1;
            RD_P_RSP:           r_ready = 1'b1;
            DONE: begin
                res_valid = 1'b1;
                res_err   = err_q;
            end
            default: busy = 1'b1;
        endcase
    end

    assign bus.job_ready     = job_ready;
    assign bus.busy          = busy;
    assign bus.res_valid     = res_valid;
    assign bus.res_err       = res_err;
    assign bus.res_data      = res_q;
    assign bus.jobs_done     = jobs_q;
    assign bus.err_cnt       = errc_q;
    assign bus.M_AXI_AWADDR  = aw_addr;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_AWVALID = aw_valid;
    assign bus.M_AXI_WDATA   = w_data;
    assign bus.M_AXI_WSTRB   = 4'hF;
    assign bus.M_AXI_WVALID  = w_valid;
    assign bus.M_AXI_BREADY  = b_ready;
    assign bus.M_AXI_ARADDR  = C_BASE_ADDR + C_OFS_P;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_ARVALID = ar_valid;
    assign bus.M_AXI_RREADY  = r_ready;
endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer: AXI4-Lite multiplier slave model plus
// directed and random jobs checked against operand-level expectations.
module tb_mult_job_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mult_job_sequencer_if #(.AW(32), .CW(16)) bus ();

    mult_job_sequencer dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0;
    bit berr_a = 0, berr_b = 0, rerr = 0;

    int aw_total = 0, w_total = 0, ar_total = 0, attr_bad = 0;
    logic [31:0] ar_addr_last = '0;
    logic [31:0] regs [4];

    logic [15:0] exp_jobs = '0;
    logic [15:0] exp_errs = '0;
    int last_accept = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AXI4-Lite multiplier slave: regs at 0x0/0x4, product read at 0x8
    initial begin : slave
        bit aw_fire, w_fire, ar_fire, b_fire, r_fire;
        bit aw_got, w_got, b_pend, b_err;
        logic [31:0] aw_addr, w_data, ar_addr;
        int aw_wait, w_wait, ar_wait, b_wait;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        aw_got = 0; w_got = 0; b_pend = 0; b_err = 0;
        aw_addr = '0; w_data = '0; ar_addr = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0;
        for (int i = 0; i < 4; i++) regs[i] = '0;
        bus.M_AXI_AWREADY = 0;
        bus.M_AXI_WREADY  = 0;
        bus.M_AXI_ARREADY = 0;
        bus.M_AXI_BVALID  = 0;
        bus.M_AXI_BRESP   = 2'b00;
        bus.M_AXI_RVALID  = 0;
        bus.M_AXI_RRESP   = 2'b00;
        bus.M_AXI_RDATA   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
                aw_got = 0; w_got = 0; b_pend = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                bus.M_AXI_AWREADY = 0;
                bus.M_AXI_WREADY  = 0;
                bus.M_AXI_ARREADY = 0;
                bus.M_AXI_BVALID  = 0;
                bus.M_AXI_RVALID  = 0;
                continue;
            end
            if (b_fire) bus.M_AXI_BVALID = 0;
            if (r_fire) bus.M_AXI_RVALID = 0;
            if (aw_fire) aw_got = 1;
            if (w_fire) w_got = 1;
            if (aw_got && w_got) begin
                regs[aw_addr[3:2]] = w_data;
                b_err = (aw_addr == 32'h0 && berr_a) ||
                        (aw_addr == 32'h4 && berr_b);
                aw_got = 0;
                w_got  = 0;
                b_pend = 1;
                b_wait = b_delay;
            end
            if (b_pend) begin
                if (b_wait == 0) begin
                    bus.M_AXI_BVALID = 1;
                    bus.M_AXI_BRESP  = b_err ? 2'b10 : 2'b00;
                    b_pend = 0;
                end else begin
                    b_wait--;
                end
            end
            if (ar_fire) begin
                bus.M_AXI_RVALID = 1;
                bus.M_AXI_RDATA  = (ar_addr == 32'h8) ?
                                   regs[0] * regs[1] : 32'hDEAD_BEEF;
                bus.M_AXI_RRESP  = rerr ? 2'b10 : 2'b00;
            end
            bus.M_AXI_AWREADY = 0;
            if (bus.M_AXI_AWVALID && !aw_got) begin
                if (aw_wait >= aw_delay) bus.M_AXI_AWREADY = 1;
                else aw_wait++;
            end
            bus.M_AXI_WREADY = 0;
            if (bus.M_AXI_WVALID && !w_got) begin
                if (w_wait >= w_delay) bus.M_AXI_WREADY = 1;
                else w_wait++;
            end
            bus.M_AXI_ARREADY = 0;
            if (bus.M_AXI_ARVALID) begin
                if (ar_wait >= ar_delay) bus.M_AXI_ARREADY = 1;
                else ar_wait++;
            end
            aw_fire = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
            w_fire  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
            ar_fire = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
            b_fire  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
            r_fire  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
            if (aw_fire) begin
                aw_addr = bus.M_AXI_AWADDR;
                aw_wait = 0;
                aw_total++;
                if (bus.M_AXI_AWPROT != 3'b000) attr_bad++;
            end
            if (w_fire) begin
                w_data = bus.M_AXI_WDATA;
                w_wait = 0;
                w_total++;
                if (bus.M_AXI_WSTRB != 4'hF) attr_bad++;
            end
            if (ar_fire) begin
                ar_addr = bus.M_AXI_ARADDR;
                ar_addr_last = ar_addr;
                ar_wait = 0;
                ar_total++;
                if (bus.M_AXI_ARPROT != 3'b000) attr_bad++;
            end
        end
    end

    task automatic do_job(input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int exp_lat, input int exp_gap);
        int t, start, lat, aw0, w0, ar0, n_aw, n_ar;
        logic [31:0] want;
        bit want_err;
        want_err = berr_a || berr_b || rerr;
        want = (berr_a || berr_b) ? 32'h0 : a * b;
        n_aw = berr_a ? 1 : 2;
        n_ar = (berr_a || berr_b) ? 0 : 1;
        aw0 = aw_total; w0 = w_total; ar0 = ar_total;
        @(negedge clk);
        bus.job_a = a;
        bus.job_b = b;
        bus.job_valid = 1;
        t = 0;
        while (!bus.job_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.job_ready) begin
            check("accept_timeout", 64'(0), 64'(1));
            bus.job_valid = 0;
            return;
        end
        start = cyc;
        if (exp_gap > 0) check("accept_gap", 64'(start - last_accept), 64'(exp_gap));
        last_accept = start;
        @(posedge clk);
        #1;
        bus.job_valid = 0;
        check("ready_busy_after_accept", 64'({bus.job_ready, bus.busy}), 64'(2'b01));
        t = 0;
        while (!bus.res_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.res_valid) begin
            check("result_timeout", 64'(0), 64'(1));
            return;
        end
        lat = cyc - start;
        if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
        check("res_data", 64'(bus.res_data), 64'(want));
        check("res_err", 64'(bus.res_err), 64'(want_err));
        check("aw_count", 64'(aw_total - aw0), 64'(n_aw));
        check("w_count", 64'(w_total - w0), 64'(n_aw));
        check("ar_count", 64'(ar_total - ar0), 64'(n_ar));
        if (n_ar == 1) check("ar_addr", 64'(ar_addr_last), 64'(32'h8));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid_ready", 64'({bus.res_valid, bus.job_ready}), 64'(2'b10));
            check("hold_data", 64'(bus.res_data), 64'(want));
        end
        bus.res_ready = 1;
        @(posedge clk);
        #1;
        bus.res_ready = 0;
        exp_jobs = exp_jobs + 16'd1;
        if (want_err) exp_errs = exp_errs + 16'd1;
        check("jobs_done", 64'(bus.jobs_done), 64'(exp_jobs));
        check("err_cnt", 64'(bus.err_cnt), 64'(exp_errs));
    endtask

    initial begin : stim
        int t, aw0;
        logic [31:0] ra, rb;
        bus.job_valid = 0;
        bus.job_a = '0;
        bus.job_b = '0;
        bus.res_ready = 0;

        // reset state
        #1;
        check("rst_ctrl", 64'({bus.job_ready, bus.busy, bus.res_valid, bus.res_err,
                               bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                               bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 64'(0));
        check("rst_cnt", 64'({bus.jobs_done, bus.err_cnt}), 64'(0));
        check("rst_res_data", 64'(bus.res_data), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        check("idle_ready", 64'({bus.job_ready, bus.busy}), 64'(2'b10));

        // single job, zero-wait slave
        do_job(32'd3, 32'd7, 0, 7, 0);

        // back-to-back jobs with res_ready immediately
        do_job(32'd1, 32'd2, 0, 7, 8);
        do_job(32'd3, 32'd4, 0, 7, 8);
        do_job(32'd5, 32'd6, 0, 7, 8);
        do_job(32'd7, 32'd8, 0, 7, 8);

        // AW/W arrival orderings
        aw_delay = 0; w_delay = 3;
        do_job(32'h0000_FFFF, 32'h0001_0001, 0, 0, 0);
        aw_delay = 3; w_delay = 0;
        do_job(32'h0000_FFFF, 32'h0001_0001, 0, 0, 0);
        aw_delay = 2; w_delay = 2;
        do_job(32'h0000_FFFF, 32'h0001_0001, 0, 0, 0);
        aw_delay = 0; w_delay = 0;

        // error responses
        berr_a = 1;
        do_job(32'd9, 32'd9, 0, 0, 0);
        berr_a = 0; berr_b = 1;
        do_job(32'd11, 32'd13, 0, 0, 0);
        berr_b = 0; rerr = 1;
        do_job(32'd6, 32'd7, 0, 0, 0);
        rerr = 0;

        // result held under back-pressure
        do_job(32'h1234_5678, 32'd16, 10, 7, 0);

        // randomized delays, operands and errors
        for (int k = 0; k < 12; k++) begin
            aw_delay = $urandom_range(3, 0);
            w_delay  = $urandom_range(3, 0);
            ar_delay = $urandom_range(3, 0);
            b_delay  = $urandom_range(2, 0);
            berr_a   = ($urandom_range(7, 0) == 0);
            berr_b   = ($urandom_range(7, 0) == 0);
            rerr     = ($urandom_range(7, 0) == 0);
            ra = $urandom;
            rb = $urandom;
            do_job(ra, rb, $urandom_range(3, 0), 0, 0);
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0;
        berr_a = 0; berr_b = 0; rerr = 0;

        // reset while waiting on write-B response
        b_delay = 4;
        aw0 = aw_total;
        @(negedge clk);
        bus.job_a = 32'd100;
        bus.job_b = 32'd200;
        bus.job_valid = 1;
        t = 0;
        while (!bus.job_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        bus.job_valid = 0;
        t = 0;
        while (!(bus.M_AXI_BREADY && aw_total >= aw0 + 2) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reached_wr_b_rsp", 64'(bus.M_AXI_BREADY), 64'(1));
        rst_n = 0;
        #1;
        check("midrst_ctrl", 64'({bus.job_ready, bus.busy, bus.res_valid, bus.res_err,
                                  bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                  bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 64'(0));
        check("midrst_cnt", 64'({bus.jobs_done, bus.err_cnt}), 64'(0));
        check("midrst_res_data", 64'(bus.res_data), 64'(0));
        exp_jobs = '0;
        exp_errs = '0;
        b_delay = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        check("post_rst_ready", 64'({bus.job_ready, bus.busy}), 64'(2'b10));
        do_job(32'd2, 32'd5, 0, 7, 0);

        check("axi_attrs", 64'(attr_bad), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
